rr_req_arbiter4: RTL and testbench

//   Four-requester arbiter sharing a single resource, with registered grants.
//   It is the sequential companion to the 4-to-2 priority encoder.
//   - Requests arrive on a 4-bit vector.
//   - One requester is granted at a time and holds the grant until it drops
//     its request or hits the hold limit.
//   - Rotating priority prevents starvation.
//   - Outputs a one-hot grant, the encoded index and a valid flag, for driving
//     the shared datapath mux.

---
 rtl/rr_req_arbiter4.sv | 125 ++++++++++++
 tb/tb_rr_req_arbiter4.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_req_arbiter4.sv
// Four-requester round-robin arbiter with registered one-hot grant,
// hold-limit preemption and descending circular priority.
module rr_req_arbiter4 #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       preempt
);

    localparam int unsigned CW =
        (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);
    localparam bit TO_EN = (HOLD_MAX != 0);
    localparam int unsigned HL = TO_EN ? HOLD_MAX - 1 : 0;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HL);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    gnt_q, gnt_d;
    logic [1:0]    idx_q, idx_d;
    logic          pre_q, pre_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    ptr_q, ptr_d;

    logic          win_found;
    logic [1:0]    win_idx;
    logic          arb;
    logic          timeout;

    // First requester found scanning ptr, ptr-1, ... (mod 4).
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] c;
            c = ptr_q - 2'(k);
            if (!win_found && req[c]) begin
                win_found = 1'b1;
                win_idx   = c;
            end
        end
    end

    assign timeout = TO_EN && (cnt_q == HOLD_LAST);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        pre_d   = 1'b0;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        arb     = 1'b0;

        case (state_q)
            S_IDLE: begin
                arb = win_found;
            end
            S_GRANT: begin
                if (!req[idx_q]) begin
                    if (win_found) begin
                        arb = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        gnt_d   = 4'b0000;
                        idx_d   = 2'd0;
                        cnt_d   = '0;
                    end
                end else if (timeout) begin
                    arb   = 1'b1;
                    pre_d = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = 4'b0000;
                idx_d   = 2'd0;
                cnt_d   = '0;
            end
        endcase

        // The winner becomes lowest priority for the next scan.
        if (arb) begin
            state_d = S_GRANT;
            gnt_d   = 4'b0001 << win_idx;
            idx_d   = win_idx;
            cnt_d   = '0;
            ptr_d   = win_idx - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gnt_q   <= 4'b0000;
            idx_q   <= 2'd0;
            pre_q   <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= 2'd3;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = |gnt_q;
    assign preempt   = pre_q;

endmodule

// File: tb/tb_rr_req_arbiter4.sv
// Scoreboard bench for rr_req_arbiter4: default-hold instance plus
// a HOLD_MAX=4 instance for the timeout scenarios.
module tb_rr_req_arbiter4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_a, req_b;
    logic [3:0] gnt_a, gnt_b;
    logic [1:0] idx_a, idx_b;
    logic       val_a, val_b;
    logic       pre_a, pre_b;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected {gnt, gnt_idx, gnt_valid, preempt}.
    logic [7:0] exp_q[$];

    rr_req_arbiter4 u_a (
        .clk(clk), .rst_n(rst_n), .req(req_a),
        .gnt(gnt_a), .gnt_idx(idx_a),
        .gnt_valid(val_a), .preempt(pre_a)
    );

    rr_req_arbiter4 #(.HOLD_MAX(4)) u_b (
        .clk(clk), .rst_n(rst_n), .req(req_b),
        .gnt(gnt_b), .gnt_idx(idx_b),
        .gnt_valid(val_b), .preempt(pre_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mk(int i, bit p);
        logic [3:0] g;
        if (i < 0) return {7'b0, p};
        g = 4'b0001 << i;
        return {g, 2'(i), 1'b1, p};
    endfunction

    function automatic logic [7:0] obs(bit sel);
        if (sel) return {gnt_b, idx_b, val_b, pre_b};
        return {gnt_a, idx_a, val_a, pre_a};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        req_a = 4'b0;
        req_b = 4'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] e, o;
        do_reset();
        n_checks++;
        o = obs(1'b0);
        if (o !== 8'h00)
            $display("FAIL reset_a: got %b expected %b", o, 8'h00);
        else n_pass++;
        for (int k = 0; k < 5; k++) begin
            req_a = 4'b0000;
            exp_q.push_back(mk(-1, 1'b0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            o = obs(1'b0);
            n_checks++;
            if (o !== e)
                $display("FAIL idle step %0d: got %b expected %b", k, o, e);
            else n_pass++;
        end
    endtask

    task automatic test_switch();
        logic [3:0] rv [3] = '{4'b1011, 4'b0011, 4'b0000};
        int         ev [3] = '{3, 1, -1};
        logic [7:0] e, o;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            req_a = rv[k];
            exp_q.push_back(mk(ev[k], 1'b0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            o = obs(1'b0);
            n_checks++;
            if (o !== e)
                $display("FAIL switch step %0d: got %b expected %b", k, o, e);
            else n_pass++;
        end
    endtask

    task automatic test_rotation();
        logic [3:0] rv [9] = '{4'b1111, 4'b1111, 4'b0111, 4'b1111,
                               4'b1011, 4'b1111, 4'b1101, 4'b1111,
                               4'b1110};
        int         ev [9] = '{3, 3, 2, 2, 1, 1, 0, 0, 3};
        logic [7:0] e, o;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            req_a = rv[k];
            exp_q.push_back(mk(ev[k], 1'b0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            o = obs(1'b0);
            n_checks++;
            if (o !== e)
                $display("FAIL rotation step %0d: got %b expected %b", k, o, e);
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        logic [7:0] e, o;
        int         w;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            req_b = 4'b0101;
            w = ((k / 4) % 2 == 0) ? 2 : 0;
            exp_q.push_back(mk(w, (k % 4 == 0) && (k != 0)));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            o = obs(1'b1);
            n_checks++;
            if (o !== e)
                $display("FAIL timeout step %0d: got %b expected %b", k, o, e);
            else n_pass++;
        end
    endtask

    task automatic test_sole_holder();
        logic [7:0] e, o;
        do_reset();
        for (int k = 0; k < 13; k++) begin
            req_b = 4'b0100;
            exp_q.push_back(mk(2, (k % 4 == 0) && (k != 0)));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            o = obs(1'b1);
            n_checks++;
            if (o !== e)
                $display("FAIL sole step %0d: got %b expected %b", k, o, e);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] e, o;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            req_a = 4'b0010;
            exp_q.push_back(mk(1, 1'b0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            o = obs(1'b0);
            n_checks++;
            if (o !== e)
                $display("FAIL pre_rst step %0d: got %b expected %b", k, o, e);
            else n_pass++;
        end
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        o = obs(1'b0);
        n_checks++;
        if (o !== 8'h00)
            $display("FAIL async_rst: got %b expected %b", o, 8'h00);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        req_a = 4'b0110;
        exp_q.push_back(mk(2, 1'b0));
        @(posedge clk); #1;
        e = exp_q.pop_front();
        o = obs(1'b0);
        n_checks++;
        if (o !== e)
            $display("FAIL post_rst: got %b expected %b", o, e);
        else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        req_a = 4'b0;
        req_b = 4'b0;
        test_reset();
        test_switch();
        test_rotation();
        test_timeout();
        test_sole_holder();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
